whack_scorer: RTL

Player-side counterpart of the mole generator. It takes the 10-bit lit-mole pattern and the 10 raw player buttons, then synchronizes and debounces the buttons and classifies each press as a hit or a miss. It tracks which moles have been whacked in the current round, keeps a 4-digit BCD score and counts strikes up to a game-over condition. Its outputs drive the LED mask (moles & ~hit_mask), the score display and the game-over indicator.

---
 rtl/whack_scorer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/whack_scorer.sv
// Player-side scorer for whack-a-mole: synchronizes and debounces the buttons,
// classifies presses against the lit moles, and keeps hit mask, BCD score and strikes.
module whack_scorer #(
  parameter int N_MOLES      = 10,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int MAX_STRIKES  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_MOLES-1:0] moles,
  input  logic               round_start,
  input  logic [N_MOLES-1:0] buttons,
  output logic [N_MOLES-1:0] hit_mask,
  output logic [15:0]        score,
  output logic [2:0]         strikes,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam int PC_W  = $clog2(N_MOLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]       STRIKE_LIMIT = 3'(MAX_STRIKES);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t             state, state_nx;
  logic [N_MOLES-1:0] sync_a, sync_b;
  logic [N_MOLES-1:0] deb, deb_q;
  logic [CNT_W-1:0]   cnt [N_MOLES];
  logic [N_MOLES-1:0] press, eff_mask, hits, misses;
  logic [N_MOLES-1:0] mask_nx;
  logic [15:0]        score_nx;
  logic [2:0]         strikes_nx;
  logic               hit_nx, miss_nx;

  function automatic logic [PC_W-1:0] popcount(input logic [N_MOLES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_MOLES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Decimal add of a small count with the carry rippled through all four digits;
  // a carry out of the top digit means the true sum exceeds 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [PC_W-1:0] n);
    logic [4:0]  carry;
    logic [4:0]  dsum;
    logic [15:0] r;
    carry = 5'(n);
    r     = '0;
    for (int d = 0; d < 4; d++) begin
      dsum = 5'(s[4*d +: 4]) + carry;
      if (dsum >= 5'd10) begin
        r[4*d +: 4] = 4'(dsum - 5'd10);
        carry       = 5'd1;
      end else begin
        r[4*d +: 4] = dsum[3:0];
        carry       = 5'd0;
      end
    end
    if (carry != 5'd0) r = 16'h9999;
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching real hardware ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_q  <= '0;
      for (int i = 0; i < N_MOLES; i++) cnt[i] <= '0;
    end else begin
      sync_a <= buttons;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < N_MOLES; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press    = deb & ~deb_q;
  assign eff_mask = round_start ? '0 : hit_mask;
  assign hits     = press & moles & ~eff_mask;
  assign misses   = press & ~moles;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    mask_nx    = hit_mask;
    score_nx   = score;
    strikes_nx = strikes;
    hit_nx     = 1'b0;
    miss_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (round_start) state_nx = PLAY;
      end
      PLAY: begin
        mask_nx = eff_mask | hits;
        if (|hits) begin
          score_nx = bcd_add(score, popcount(hits));
          hit_nx   = 1'b1;
        end
        if (|misses) begin
          strikes_nx = strikes + 3'd1;
          miss_nx    = 1'b1;
          if (strikes_nx == STRIKE_LIMIT) state_nx = OVER;
        end
      end
      OVER: ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hit_mask   <= '0;
      score      <= '0;
      strikes    <= '0;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      hit_mask   <= mask_nx;
      score      <= score_nx;
      strikes    <= strikes_nx;
      game_over  <= (state_nx == OVER);
      hit_pulse  <= hit_nx;
      miss_pulse <= miss_nx;
    end
  end

endmodule
